rule_unpacker: RTL and testbench
================================

Name: rule_unpacker

Overview:
- Consumer end of the port-group rule stream.
- Accepts 64-bit beats, each carrying four 16-bit rule slots; value 0 marks an unused slot.
- Drops empty slots and serialises the remaining rule IDs, one per cycle, with recomputed sop/eop for the per-rule downstream stage (rule-to-string/verification lookup).
- Guarantees exactly one output eop per input packet, including packets with no surviving rules.

Parameters:
- DATA_WIDTH, 64, input beat width.
- SLOT_WIDTH, 16, width of one rule slot; NUM_SLOTS = DATA_WIDTH/SLOT_WIDTH = 4.
- CNT_WIDTH, 32, width of the statistics counters.

Ports:
- clk  in  1  sole clock.
- rst_n  in  1  reset, synchronous, active-low.
- in_usr_data  in  DATA_WIDTH  slot k occupies bits [SLOT_WIDTH*k+SLOT_WIDTH-1 : SLOT_WIDTH*k].
- in_usr_valid  in  1  beat valid.
- in_usr_sop  in  1  first beat of packet.
- in_usr_eop  in  1  last beat of packet.
- in_usr_empty  in  3  ignored; upstream always drives 0.
- in_usr_ready  out  1  beat accepted when valid & ready.
- out_rule_data  out  SLOT_WIDTH  rule ID; 0 when out_rule_null.
- out_rule_valid  out  1  output valid.
- out_rule_sop  out  1  first output item of packet.
- out_rule_eop  out  1  last output item of packet.
- out_rule_null  out  1  terminator item; the packet had no nonzero slots after the last emitted rule.
- out_rule_ready  in  1  downstream accept.
- rule_cnt  out  CNT_WIDTH  rules emitted, null terminators excluded.
- pkt_cnt  out  CNT_WIDTH  output eops emitted.
- null_pkt_cnt  out  CNT_WIDTH  packets whose only output item was a null terminator.
- sop_err_cnt  out  CNT_WIDTH  sop accepted while a packet was open.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - state=IDLE, holding mask=0, in_pkt=0, first=1.
  - All counters 0; out_rule_valid=0, in_usr_ready=0 on the following cycle.
  - Reset mid-packet discards the held beat; no eop is emitted for it.
- Holding register: beat data, mask[NUM_SLOTS-1:0] with bit k = (slot k != 0), beat_eop, beat_sop.
- States:
  - IDLE: no held beat.
  - EMIT: a held beat has items left to present.
- in_usr_ready = (state==IDLE) | (out fire & last item of held beat this cycle).
  - Gives back-to-back throughput of one rule per cycle; no combinational path from in_usr_valid to in_usr_ready.
- Accept in IDLE or on the last item (cycle N): load holding register, go to EMIT.
  - First output item is valid in cycle N+1.
  - Output is driven from the holding register, so out_rule_* is stable while out_rule_valid & !out_rule_ready.
- Item selection in EMIT:
  - Lowest set mask bit, slot 0 first; out_rule_data = that slot.
  - On fire, clear that mask bit.
- eop:
  - Set on the item that empties the mask when beat_eop=1.
  - If beat_eop=1 and mask==0 at load, present one null item: data 0, null=1, eop=1.
- Beats with mask==0 and eop=0 produce no output; they are consumed the following cycle (EMIT state, 1 cycle).
- out_rule_sop = first; first <= 1 on an eop fire, first <= 0 on any other fire.
  - A null-only packet therefore carries sop=1, eop=1, null=1.
- in_pkt:
  - Set on accepting a beat with sop & !eop; cleared on accepting an eop beat.
  - Accepting sop while in_pkt=1 increments sop_err_cnt; processing continues as a new packet with no synthetic eop.
- Last-item definition: mask has exactly one bit set (or mask==0 with beat_eop, i.e. the null item), and the item fires.
- Counters:
  - Increment on out fire.
  - Wrap modulo 2^CNT_WIDTH without saturation.
  - pkt_cnt and null_pkt_cnt may increment on the same cycle.

Decomposition:
- Shared package holds SLOT_WIDTH, NUM_SLOTS and the state_t enum {IDLE, EMIT} alongside the existing rule typedefs.
- One sub-module: slot_prio_enc, a combinational lowest-set-bit encoder (NUM_SLOTS in → index + onehot + last flag), reused by other slot-based consumers.

Test Plan:
- Single beat sop&eop, data 0x0004_0000_0003_0002, ready=1:
  - Outputs 2 (sop), 3, 4 (eop) on consecutive cycles starting one cycle after accept.
  - rule_cnt=3, pkt_cnt=1.
- Beats {sop, 0x0000_0000_0000_0007} then {eop, all zero}:
  - Outputs 7 (sop, !eop), then null (eop, null, data 0).
  - null_pkt_cnt=0, pkt_cnt=1.
- Single beat sop&eop all zero:
  - One item with sop=eop=null=1, then idle.
  - null_pkt_cnt=1, rule_cnt=0.
- Full beats 0x0004_0003_0002_0001 ×3 (eop on 3rd), out_rule_ready toggling 1/0 every cycle:
  - 12 items in order 1,2,3,4 ×3; data held stable during stalls.
  - in_usr_ready high only on the cycle the 4th item of each beat fires.
- Sop accepted mid-packet, then packet terminated:
  - sop_err_cnt=1; the new packet's first item carries sop=1.
- rst_n low during EMIT with 3 items pending:
  - Next cycle out_rule_valid=0, all counters 0.
  - Subsequent packet {sop&eop, 0x0000_0000_0000_0009} yields 9 with sop=eop=1.

Source files
------------

// File: rtl/rule_unpacker_pkg.sv
// Shared types for the port-group rule stream consumers: slot geometry,
// rule ID type, the unpacker FSM state and its debug view.
package rule_unpacker_pkg;

   localparam int DATA_WIDTH = 64;
   localparam int SLOT_WIDTH = 16;
   localparam int NUM_SLOTS  = DATA_WIDTH / SLOT_WIDTH;
   localparam int CNT_WIDTH  = 32;

   // One rule slot; the all-zero value marks an unused slot.
   typedef logic [SLOT_WIDTH-1:0] rule_id_t;

   typedef enum logic {
      IDLE = 1'b0,  // no beat held
      EMIT = 1'b1   // a held beat still has items to present
   } state_t;

   // Observable internal state of the unpacker, for checkers and debug.
   typedef struct packed {
      state_t state;
      logic   beat_sop;
      logic   beat_eop;
      logic   in_pkt;
      logic   first;
   } unpack_dbg_t;

endpackage

// File: rtl/slot_prio_enc.sv
// Lowest-set-bit encoder over a slot occupancy mask. Slot 0 has the highest
// priority. Also reports whether any bit is set and whether exactly one is.
module slot_prio_enc
   import rule_unpacker_pkg::*;
#(
   parameter int N     = NUM_SLOTS,
   parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]     mask,
   output logic [IDX_W-1:0] idx,
   output logic [N-1:0]     onehot,
   output logic             any,
   output logic             last
);

   // Scan from the top down so the lowest set bit is the one that sticks.
   always_comb begin
      idx    = '0;
      onehot = '0;
      for (int k = N - 1; k >= 0; k--) begin
         if (mask[k]) begin
            idx       = IDX_W'(k);
            onehot    = '0;
            onehot[k] = 1'b1;
         end
      end
   end

   assign any  = |mask;
   // Exactly one bit set: clearing the lowest set bit leaves nothing.
   assign last = any & ((mask & (mask - N'(1))) == '0);

endmodule

// File: rtl/rule_unpacker.sv
// Consumer end of the port-group rule stream. Each 64-bit beat carries four
// 16-bit rule slots; zero slots are dropped and the surviving rule IDs are
// serialised one per cycle with recomputed sop/eop. Every input packet yields
// exactly one output eop, using a null terminator item when no rule is left
// to carry it.
//
// Handshake: on both interfaces a transfer happens on a rising clk edge where
// valid & ready are both high. A producer holding valid keeps its payload
// stable until the transfer; in_usr_ready never depends combinationally on
// in_usr_valid, and out_rule_* is driven from registers only, so it holds
// steady while out_rule_valid & !out_rule_ready.
module rule_unpacker
   import rule_unpacker_pkg::*;
#(
   parameter int DATA_WIDTH = 64,
   parameter int SLOT_WIDTH = 16,
   parameter int CNT_WIDTH  = 32
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [DATA_WIDTH-1:0] in_usr_data,
   input  logic                  in_usr_valid,
   input  logic                  in_usr_sop,
   input  logic                  in_usr_eop,
   input  logic [2:0]            in_usr_empty,
   output logic                  in_usr_ready,
   output logic [SLOT_WIDTH-1:0] out_rule_data,
   output logic                  out_rule_valid,
   output logic                  out_rule_sop,
   output logic                  out_rule_eop,
   output logic                  out_rule_null,
   input  logic                  out_rule_ready,
   output logic [CNT_WIDTH-1:0]  rule_cnt,
   output logic [CNT_WIDTH-1:0]  pkt_cnt,
   output logic [CNT_WIDTH-1:0]  null_pkt_cnt,
   output logic [CNT_WIDTH-1:0]  sop_err_cnt,
   output unpack_dbg_t           dbg
);

   localparam int NS = DATA_WIDTH / SLOT_WIDTH;
   localparam int IW = (NS > 1) ? $clog2(NS) : 1;

   state_t                state;
   state_t                state_nxt;

   // Holding register for the beat being serialised.
   logic [DATA_WIDTH-1:0] hold_data;
   logic [NS-1:0]         mask;
   logic                  beat_sop;
   logic                  beat_eop;

   logic                  in_pkt;
   logic                  first;
   logic                  live;

   logic [NS-1:0]         beat_mask;
   logic [SLOT_WIDTH-1:0] slots [NS];

   logic [IW-1:0]         sel_idx;
   logic [NS-1:0]         sel_onehot;
   logic                  sel_any;
   logic                  sel_last;

   logic                  item_last;
   logic                  drop_beat;
   logic                  out_fire;
   logic                  last_fire;
   logic                  accept;

   // Upstream always drives zero here; the beat width is fixed.
   logic                  unused_empty;
   assign unused_empty = ^in_usr_empty;

   // Occupancy of the incoming beat: bit k set when slot k holds a rule.
   always_comb begin
      beat_mask = '0;
      for (int k = 0; k < NS; k++) begin
         beat_mask[k] = |in_usr_data[k*SLOT_WIDTH +: SLOT_WIDTH];
      end
   end

   // Split the held beat into its slots for the output mux.
   always_comb begin
      for (int k = 0; k < NS; k++) begin
         slots[k] = hold_data[k*SLOT_WIDTH +: SLOT_WIDTH];
      end
   end

   slot_prio_enc #(
      .N     (NS),
      .IDX_W (IW)
   ) u_prio (
      .mask   (mask),
      .idx    (sel_idx),
      .onehot (sel_onehot),
      .any    (sel_any),
      .last   (sel_last)
   );

   // Next state, output item and both handshakes, all from registered state.
   always_comb begin
      state_nxt      = state;
      out_rule_valid = 1'b0;
      out_rule_data  = '0;
      out_rule_eop   = 1'b0;
      out_rule_null  = 1'b0;
      item_last      = 1'b0;
      drop_beat      = 1'b0;

      case (state)
         IDLE: begin
         end
         EMIT: begin
            if (sel_any) begin
               out_rule_valid = 1'b1;
               out_rule_data  = slots[sel_idx];
               out_rule_eop   = beat_eop & sel_last;
               item_last      = sel_last;
            end else if (beat_eop) begin
               // Nothing left to carry the eop, so close with a null item.
               out_rule_valid = 1'b1;
               out_rule_null  = 1'b1;
               out_rule_eop   = 1'b1;
               item_last      = 1'b1;
            end else begin
               // Empty mid-packet beat: nothing to emit, just retire it.
               drop_beat = 1'b1;
            end
         end
         default: begin
         end
      endcase

      out_fire     = out_rule_valid & out_rule_ready;
      last_fire    = out_fire & item_last;
      in_usr_ready = live & ((state == IDLE) | last_fire);
      accept       = in_usr_valid & in_usr_ready;

      if (accept) begin
         state_nxt = EMIT;
      end else if (last_fire | drop_beat) begin
         state_nxt = IDLE;
      end
   end

   assign out_rule_sop = first;

   // FSM state register.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Keeps the input closed for the first cycle after reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         live <= 1'b0;
      end else begin
         live <= 1'b1;
      end
   end

   // Load a new beat on accept; otherwise retire the presented slot on fire.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         hold_data <= '0;
         mask      <= '0;
         beat_sop  <= 1'b0;
         beat_eop  <= 1'b0;
      end else if (accept) begin
         hold_data <= in_usr_data;
         mask      <= beat_mask;
         beat_sop  <= in_usr_sop;
         beat_eop  <= in_usr_eop;
      end else if (out_fire) begin
         mask <= mask & ~sel_onehot;
      end
   end

   // Output sop tracking. An accepted sop beat reopens the packet even when
   // the previous one never closed, so its first item is marked sop.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         first <= 1'b1;
      end else if (accept & in_usr_sop) begin
         first <= 1'b1;
      end else if (out_fire) begin
         first <= out_rule_eop;
      end
   end

   // Input packet framing and detection of a sop inside an open packet.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         in_pkt      <= 1'b0;
         sop_err_cnt <= '0;
      end else if (accept) begin
         if (in_usr_sop & in_pkt) begin
            sop_err_cnt <= sop_err_cnt + CNT_WIDTH'(1);
         end
         if (in_usr_eop) begin
            in_pkt <= 1'b0;
         end else if (in_usr_sop) begin
            in_pkt <= 1'b1;
         end
      end
   end

   // Output statistics, all wrapping.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rule_cnt     <= '0;
         pkt_cnt      <= '0;
         null_pkt_cnt <= '0;
      end else if (out_fire) begin
         if (!out_rule_null) begin
            rule_cnt <= rule_cnt + CNT_WIDTH'(1);
         end
         if (out_rule_eop) begin
            pkt_cnt <= pkt_cnt + CNT_WIDTH'(1);
         end
         if (out_rule_null & first) begin
            null_pkt_cnt <= null_pkt_cnt + CNT_WIDTH'(1);
         end
      end
   end

   assign dbg.state    = state;
   assign dbg.beat_sop = beat_sop;
   assign dbg.beat_eop = beat_eop;
   assign dbg.in_pkt   = in_pkt;
   assign dbg.first    = first;

endmodule

// File: tb/tb_rule_unpacker.sv
// Directed bench for rule_unpacker: beats are driven in sequence, a reference
// model expands each beat into the expected output items, and a monitor pops
// and compares them as the DUT hands them over.
module tb_rule_unpacker;
   import rule_unpacker_pkg::*;

   // ---------------- clock / reset ----------------
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   always #5 clk = ~clk;

   logic [63:0] in_usr_data = '0;
   logic        in_usr_valid = 1'b0;
   logic        in_usr_sop = 1'b0;
   logic        in_usr_eop = 1'b0;
   logic [2:0]  in_usr_empty = '0;
   logic        in_usr_ready;
   logic [15:0] out_rule_data;
   logic        out_rule_valid;
   logic        out_rule_sop;
   logic        out_rule_eop;
   logic        out_rule_null;
   logic        out_rule_ready = 1'b0;
   logic [31:0] rule_cnt;
   logic [31:0] pkt_cnt;
   logic [31:0] null_pkt_cnt;
   logic [31:0] sop_err_cnt;
   unpack_dbg_t dbg;

   rule_unpacker dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .in_usr_data    (in_usr_data),
      .in_usr_valid   (in_usr_valid),
      .in_usr_sop     (in_usr_sop),
      .in_usr_eop     (in_usr_eop),
      .in_usr_empty   (in_usr_empty),
      .in_usr_ready   (in_usr_ready),
      .out_rule_data  (out_rule_data),
      .out_rule_valid (out_rule_valid),
      .out_rule_sop   (out_rule_sop),
      .out_rule_eop   (out_rule_eop),
      .out_rule_null  (out_rule_null),
      .out_rule_ready (out_rule_ready),
      .rule_cnt       (rule_cnt),
      .pkt_cnt        (pkt_cnt),
      .null_pkt_cnt   (null_pkt_cnt),
      .sop_err_cnt    (sop_err_cnt),
      .dbg            (dbg)
   );

   // ---------------- scoreboard state ----------------
   int          n_tests = 0;
   int          n_fail = 0;
   logic [18:0] exp_q[$];   // {null, sop, eop, data}
   bit          tb_first = 1'b1;
   bit          tb_in_pkt = 1'b0;
   int          exp_rule = 0;
   int          exp_pkt = 0;
   int          exp_null = 0;
   int          exp_err = 0;

   bit          toggle_mode = 1'b0;
   bit          ready_level = 1'b1;
   bit          tog_armed = 1'b0;
   int          tog_items = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference model: expand one input beat into the items it must produce.
   task automatic model_beat(input logic [63:0] data, input bit sop, input bit eop);
      int          n_nz;
      int          seen;
      logic [15:0] s;
      bit          e;
      if (sop) begin
         if (tb_in_pkt) exp_err++;
         tb_first = 1'b1;
      end
      if (eop) tb_in_pkt = 1'b0;
      else if (sop) tb_in_pkt = 1'b1;
      n_nz = 0;
      for (int k = 0; k < 4; k++) begin
         s = data[k*16 +: 16];
         if (s != 16'h0) n_nz++;
      end
      seen = 0;
      for (int k = 0; k < 4; k++) begin
         s = data[k*16 +: 16];
         if (s != 16'h0) begin
            seen++;
            e = eop && (seen == n_nz);
            exp_q.push_back({1'b0, tb_first, e, s});
            exp_rule++;
            if (e) exp_pkt++;
            tb_first = e;
         end
      end
      if (n_nz == 0 && eop) begin
         exp_q.push_back({1'b1, tb_first, 1'b1, 16'h0});
         exp_pkt++;
         if (tb_first) exp_null++;
         tb_first = 1'b1;
      end
   endtask

   task automatic model_reset();
      exp_q.delete();
      tb_first  = 1'b1;
      tb_in_pkt = 1'b0;
      exp_rule  = 0;
      exp_pkt   = 0;
      exp_null  = 0;
      exp_err   = 0;
   endtask

   // ---------------- driver tasks ----------------
   // Called just after a rising edge; returns just after the accepting edge.
   task automatic send_beat(input logic [63:0] data, input bit sop, input bit eop);
      bit got;
      model_beat(data, sop, eop);
      in_usr_data  = data;
      in_usr_sop   = sop;
      in_usr_eop   = eop;
      in_usr_valid = 1'b1;
      got = 1'b0;
      for (int i = 0; i < 200 && !got; i++) begin
         @(negedge clk);
         if (in_usr_ready) got = 1'b1;
         @(posedge clk);
         #1;
      end
      if (!got) check("accept_timeout", 32'(got), 32'd1);
      in_usr_valid = 1'b0;
      in_usr_sop   = 1'b0;
      in_usr_eop   = 1'b0;
      in_usr_data  = '0;
   endtask

   // Wait for all expected items, then check idle output and all counters.
   task automatic drain(input string tag);
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 300) begin
         @(negedge clk);
         n++;
      end
      check({tag, "_drain"}, 32'(exp_q.size()), 32'd0);
      @(posedge clk);
      #1;
      check({tag, "_idle_valid"}, 32'(out_rule_valid), 32'd0);
      check({tag, "_rule_cnt"}, rule_cnt, 32'(exp_rule));
      check({tag, "_pkt_cnt"}, pkt_cnt, 32'(exp_pkt));
      check({tag, "_null_pkt_cnt"}, null_pkt_cnt, 32'(exp_null));
      check({tag, "_sop_err_cnt"}, sop_err_cnt, 32'(exp_err));
   endtask

   // Downstream ready: fixed level, or toggling every cycle.
   always @(posedge clk) begin
      #1;
      if (toggle_mode) out_rule_ready = ~out_rule_ready;
      else out_rule_ready = ready_level;
   end

   // ---------------- monitor ----------------
   always @(negedge clk) begin : mon
      logic [18:0] cur;
      logic [18:0] exp;
      logic [18:0] prev_item;
      bit          prev_stall;
      bit          fire;
      if (rst_n) begin
         cur  = {out_rule_null, out_rule_sop, out_rule_eop, out_rule_data};
         fire = out_rule_valid && out_rule_ready;
         if (prev_stall) check("stall_hold", {out_rule_valid, cur}, {1'b1, prev_item});
         if (tog_armed && tog_items < 12)
            check("in_ready_4th", 32'(in_usr_ready), 32'(fire && (tog_items % 4 == 3)));
         if (fire) begin
            if (exp_q.size() == 0) begin
               check("unexpected_item", 32'(exp_q.size()), 32'd1);
            end else begin
               exp = exp_q.pop_front();
               check("item", 32'(cur), 32'(exp));
            end
            if (tog_armed && tog_items < 12) tog_items++;
         end
         prev_stall = out_rule_valid && !out_rule_ready;
         prev_item  = cur;
      end else begin
         prev_stall = 1'b0;
      end
   end

   // Watchdog so the run always ends.
   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, tests=%0d failed=%0d", n_tests, n_fail);
      $fatal(1, "watchdog");
   end

   // ---------------- directed sequence ----------------
   initial begin
      rst_n = 1'b0;
      ready_level = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("rst_valid", 32'(out_rule_valid), 32'd0);
      check("rst_in_ready", 32'(in_usr_ready), 32'd0);
      check("rst_state", 32'(dbg.state), 32'(IDLE));
      check("rst_rule_cnt", rule_cnt, 32'd0);
      check("rst_pkt_cnt", pkt_cnt, 32'd0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      check("ready_after_rst", 32'(in_usr_ready), 32'd1);

      // Single beat, three rules with a hole in slot 2.
      send_beat(64'h0004_0000_0003_0002, 1'b1, 1'b1);
      check("t1_first_item", {out_rule_valid, out_rule_sop, out_rule_data}, {1'b1, 1'b1, 16'h0002});
      drain("t1");
      check("t1_rule_cnt_abs", rule_cnt, 32'd3);
      check("t1_pkt_cnt_abs", pkt_cnt, 32'd1);

      // Rule then an empty eop beat: null terminator carries the eop.
      send_beat(64'h0000_0000_0000_0007, 1'b1, 1'b0);
      send_beat(64'h0, 1'b0, 1'b1);
      drain("t2");
      check("t2_null_pkt_cnt_abs", null_pkt_cnt, 32'd0);

      // Empty single-beat packet.
      send_beat(64'h0, 1'b1, 1'b1);
      check("t3_null_item", {out_rule_valid, out_rule_sop, out_rule_eop, out_rule_null, out_rule_data},
            {1'b1, 1'b1, 1'b1, 1'b1, 16'h0});
      drain("t3");
      check("t3_null_pkt_cnt_abs", null_pkt_cnt, 32'd1);

      // Three full beats with downstream ready toggling.
      toggle_mode = 1'b1;
      send_beat(64'h0004_0003_0002_0001, 1'b1, 1'b0);
      tog_armed = 1'b1;
      send_beat(64'h0004_0003_0002_0001, 1'b0, 1'b0);
      send_beat(64'h0004_0003_0002_0001, 1'b0, 1'b1);
      drain("t4");
      check("t4_items_seen", 32'(tog_items), 32'd12);
      toggle_mode = 1'b0;
      ready_level = 1'b1;
      @(posedge clk);
      #1;

      // A sop arrives while a packet is still open.
      send_beat(64'h0000_0000_0000_0005, 1'b1, 1'b0);
      send_beat(64'h0000_0000_0000_0006, 1'b1, 1'b1);
      drain("t5");
      check("t5_sop_err_abs", sop_err_cnt, 32'd1);

      // Reset while a beat with three pending items is held.
      ready_level = 1'b0;
      @(posedge clk);
      #1;
      send_beat(64'h0000_0003_0002_0001, 1'b1, 1'b0);
      check("t6_pending", 32'(out_rule_valid), 32'd1);
      rst_n = 1'b0;
      model_reset();
      @(posedge clk);
      #1;
      check("t6_rst_valid", 32'(out_rule_valid), 32'd0);
      check("t6_rst_in_ready", 32'(in_usr_ready), 32'd0);
      check("t6_rst_rule_cnt", rule_cnt, 32'd0);
      check("t6_rst_pkt_cnt", pkt_cnt, 32'd0);
      check("t6_rst_null_cnt", null_pkt_cnt, 32'd0);
      check("t6_rst_err_cnt", sop_err_cnt, 32'd0);
      rst_n = 1'b1;
      ready_level = 1'b1;
      @(posedge clk);
      #1;
      send_beat(64'h0000_0000_0000_0009, 1'b1, 1'b1);
      check("t6_after_item", {out_rule_valid, out_rule_sop, out_rule_eop, out_rule_data},
            {1'b1, 1'b1, 1'b1, 16'h0009});
      drain("t6");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
